ro_trng_ctrl: RTL and testbench

RO_TRNG_CTRL -- requirements
Module: ro_trng_ctrl

---
 rtl/trng_pkg.sv | 15 +
 rtl/ro_sync.sv | 26 ++
 rtl/ro_trng_ctrl.sv | 152 +++++++++++++++
 tb/tb_ro_trng_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the ring-oscillator TRNG controller.
package trng_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } trng_state_e;

    // Number of flops used to bring the free-running oscillator outputs into clk
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/ro_sync.sv
// Per-bit multi-flop synchronizer for the asynchronous ring-oscillator outputs.
module ro_sync
    import trng_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_DEPTH-1:0][WIDTH-1:0] sync_p;

    // Shift each oscillator bit through SYNC_DEPTH flops; the last one is safe to use
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = sync_p[SYNC_DEPTH-1];

endmodule

// File: rtl/ro_trng_ctrl.sv
// Ring-oscillator TRNG controller: enables the oscillators, waits out a warm-up
// period, samples the XOR of the synchronized oscillator outputs at a fixed
// divider rate and assembles WORD_W-bit words with a valid/ready hand-off.
// Optional build macro TRNG_VON_NEUMANN_EN inserts a Von Neumann debiaser
// (raw pairs 01 -> 0, 10 -> 1, 00/11 dropped) in front of the word register.
module ro_trng_ctrl
    import trng_pkg::*;
#(
    parameter int NUM_RO        = 3,
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 8,
    parameter int WORD_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [NUM_RO-1:0] ro_en,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy
);

    // Counter widths follow the largest value each counter ever holds
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int BIT_W  = $clog2(WORD_W + 1);

    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(WORD_W);

    trng_state_e       state;
    logic [WARM_W-1:0] warm_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [NUM_RO-1:0] ro_sync_q;
    logic              tick;
    logic              raw_bit;
    logic              bit_vld;
    logic              bit_val;

    ro_sync #(
        .WIDTH (NUM_RO)
    ) u_ro_sync (
        .clk (clk),
        .rst (rst),
        .d   (ro_in),
        .q   (ro_sync_q)
    );

    assign tick    = (state == ST_SAMPLE) && (div_cnt == DIV_LAST);
    assign raw_bit = ^ro_sync_q;
    assign busy    = (state != ST_IDLE);
    assign ro_en   = {NUM_RO{state != ST_IDLE}};

`ifdef TRNG_VON_NEUMANN_EN
    logic pair_have;
    logic pair_first;

    assign bit_vld = tick && pair_have && (pair_first != raw_bit);
    assign bit_val = pair_first;

    // Pair consecutive raw bits; pairing restarts whenever SAMPLE is re-entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_have  <= 1'b0;
            pair_first <= 1'b0;
        end else if (state != ST_SAMPLE) begin
            pair_have  <= 1'b0;
        end else if (tick) begin
            if (!pair_have) begin
                pair_have  <= 1'b1;
                pair_first <= raw_bit;
            end else begin
                pair_have  <= 1'b0;
            end
        end
    end
`else
    assign bit_vld = tick;
    assign bit_val = raw_bit;
`endif

    // Main FSM with warm-up, sample divider, bit counter and word register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            warm_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
        end else if (stop) begin
            // Abort wins over start, ready and ticks; any partial word is dropped
            state     <= ST_IDLE;
            warm_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_WARMUP;
                        warm_cnt <= WARM_LOAD;
                    end
                end
                ST_WARMUP: begin
                    if (warm_cnt == '0) begin
                        state    <= ST_SAMPLE;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        rnd_data <= '0;
                    end else begin
                        warm_cnt <= warm_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                    if (bit_vld) begin
                        rnd_data <= {rnd_data[WORD_W-2:0], bit_val};
                        if (bit_cnt == BIT_LAST) begin
                            state     <= ST_HOLD;
                            rnd_valid <= 1'b1;
                            bit_cnt   <= BIT_FULL;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (rnd_valid && rnd_ready) begin
                        state     <= ST_SAMPLE;
                        rnd_valid <= 1'b0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        rnd_data  <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_trng_ctrl.sv
// Self-checking bench for ro_trng_ctrl with a queue-based reference model.
module tb_ro_trng_ctrl;

    localparam int NUM_RO = 3;
    localparam int WARMUP = 16;
    localparam int DIV    = 4;
    localparam int WORD_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              rnd_ready;
    logic [NUM_RO-1:0] ro_en;
    logic [NUM_RO-1:0] ro_in;
    logic [WORD_W-1:0] rnd_data;
    logic              rnd_valid;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: accepted bits queue plus Von Neumann pair memory
    logic acc_q[$];
    logic m_have;
    logic m_first;

    always #5 clk = ~clk;

    ro_trng_ctrl #(
        .NUM_RO        (NUM_RO),
        .WARMUP_CYCLES (WARMUP),
        .SAMPLE_DIV    (DIV),
        .WORD_W        (WORD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .ro_en     (ro_en),
        .ro_in     (ro_in),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive an oscillator vector whose XOR equals b
    task automatic drive_bit(input logic b);
        logic [NUM_RO-1:0] v;
        v = NUM_RO'($urandom);
        if ((^v) != b) v[0] = ~v[0];
        ro_in = v;
    endtask

    task automatic model_clear();
        acc_q.delete();
        m_have  = 1'b0;
        m_first = 1'b0;
    endtask

    task automatic model_raw(input logic b);
`ifdef TRNG_VON_NEUMANN_EN
        if (!m_have) begin
            m_have  = 1'b1;
            m_first = b;
        end else begin
            m_have = 1'b0;
            if (m_first != b) acc_q.push_back(m_first);
        end
`else
        acc_q.push_back(b);
`endif
    endtask

    // Word value = accepted bits read MSB-first, modulo 2^WORD_W
    function automatic logic [WORD_W-1:0] exp_word();
        longint w;
        w = 0;
        foreach (acc_q[i]) w = (w * 2 + longint'(acc_q[i])) % (longint'(1) << WORD_W);
        return WORD_W'(w);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
    endtask

    // Feed raw bits one per tick; first tick comes first_wait cycles after the
    // reference edge (just passed). Stops when a full word is expected.
    task automatic feed(input int first_wait, input int nraw, input logic [31:0] pat,
                        input bit rand_bits, output bit done);
        logic b;
        logic exp_v;
        done = 1'b0;
        model_clear();
        for (int i = 0; i < nraw && !done; i++) begin
            b = rand_bits ? 1'($urandom_range(0, 1)) : pat[nraw-1-i];
            drive_bit(b);
            wait_cyc(((i == 0) ? first_wait : DIV) - 1);
            n_chk++;
            if (rnd_valid !== 1'b0) $display("FAIL pre_tick_valid raw=%0d got %b exp 0", i, rnd_valid);
            else n_pass++;
            wait_cyc(1);
            model_raw(b);
            exp_v = (acc_q.size() == WORD_W);
            n_chk++;
            if (rnd_valid !== exp_v) $display("FAIL tick_valid raw=%0d got %b exp %b", i, rnd_valid, exp_v);
            else n_pass++;
            n_chk++;
            if (rnd_data !== exp_word()) $display("FAIL tick_data raw=%0d got %h exp %h", i, rnd_data, exp_word());
            else n_pass++;
            done = exp_v;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; rnd_ready = 1'b0; ro_in = '0;
        wait_cyc(2);
        n_chk++; if (ro_en !== 3'b000) $display("FAIL rst_ro_en got %b exp 000", ro_en); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (rnd_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", rnd_valid); else n_pass++;
        n_chk++; if (rnd_data !== 8'h00) $display("FAIL rst_data got %h exp 00", rnd_data); else n_pass++;
        rst = 1'b0;
        wait_cyc(1);
        n_chk++; if (busy !== 1'b0) $display("FAIL post_rst_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_start_word();
        bit done;
        pulse_start();
        n_chk++; if (ro_en !== 3'b111) $display("FAIL start_ro_en got %b exp 111", ro_en); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL start_busy got %b exp 1", busy); else n_pass++;
        feed(WARMUP + DIV, 8, 32'hB2, 1'b0, done);
`ifndef TRNG_VON_NEUMANN_EN
        n_chk++; if (done !== 1'b1) $display("FAIL word_done got %b exp 1", done); else n_pass++;
        n_chk++; if (rnd_data !== 8'hB2) $display("FAIL word_B2 got %h exp b2", rnd_data); else n_pass++;
`endif
        pulse_stop();
    endtask

    task automatic test_hold();
        bit done;
        pulse_start();
        feed(WARMUP + DIV, 200, 32'h0, 1'b1, done);
        n_chk++; if (done !== 1'b1) $display("FAIL hold_word_done got %b exp 1", done); else n_pass++;
        for (int c = 0; c < 20; c++) begin
            ro_in = NUM_RO'($urandom);
            wait_cyc(1);
            n_chk++; if (rnd_valid !== 1'b1) $display("FAIL hold_valid c=%0d got %b exp 1", c, rnd_valid); else n_pass++;
            n_chk++; if (rnd_data !== exp_word()) $display("FAIL hold_data c=%0d got %h exp %h", c, rnd_data, exp_word()); else n_pass++;
        end
        rnd_ready = 1'b1;
        wait_cyc(1);
        rnd_ready = 1'b0;
        n_chk++; if (rnd_valid !== 1'b0) $display("FAIL ready_drop got %b exp 0", rnd_valid); else n_pass++;
        n_chk++; if (ro_en !== 3'b111) $display("FAIL ready_ro_en got %b exp 111", ro_en); else n_pass++;
        feed(DIV, 200, 32'h0, 1'b1, done);
        n_chk++; if (done !== 1'b1) $display("FAIL second_word_done got %b exp 1", done); else n_pass++;
        pulse_stop();
    endtask

    task automatic test_back_to_back();
        bit done;
        pulse_start();
        wait_cyc(5);
        pulse_start();
        feed(WARMUP + DIV - 6, 200, 32'h0, 1'b1, done);
        n_chk++; if (done !== 1'b1) $display("FAIL b2b_word1 got %b exp 1", done); else n_pass++;
        for (int w = 0; w < 2; w++) begin
            rnd_ready = 1'b1;
            wait_cyc(1);
            rnd_ready = 1'b0;
            feed(DIV, 200, 32'h0, 1'b1, done);
            n_chk++; if (done !== 1'b1) $display("FAIL b2b_word%0d got %b exp 1", w + 2, done); else n_pass++;
        end
        pulse_stop();
    endtask

    task automatic test_pairs();
        bit done;
        pulse_start();
        feed(WARMUP + DIV, 10, 32'h1E2, 1'b0, done);
`ifdef TRNG_VON_NEUMANN_EN
        n_chk++; if (done !== 1'b0) $display("FAIL vn_done got %b exp 0", done); else n_pass++;
        n_chk++; if (rnd_data !== 8'h03) $display("FAIL vn_data got %h exp 03", rnd_data); else n_pass++;
`else
        n_chk++; if (done !== 1'b1) $display("FAIL raw_done got %b exp 1", done); else n_pass++;
        n_chk++; if (rnd_data !== 8'h78) $display("FAIL raw_data got %h exp 78", rnd_data); else n_pass++;
`endif
        pulse_stop();
    endtask

    task automatic test_stop();
        bit done;
        bit seen;
        pulse_start();
        feed(WARMUP + DIV, 4, 32'h0, 1'b1, done);
        drive_bit(1'($urandom_range(0, 1)));
        wait_cyc(DIV - 1);
        stop = 1'b1;
        start = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        start = 1'b0;
        n_chk++; if (busy !== 1'b0) $display("FAIL stop_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (ro_en !== 3'b000) $display("FAIL stop_ro_en got %b exp 000", ro_en); else n_pass++;
        n_chk++; if (rnd_valid !== 1'b0) $display("FAIL stop_valid got %b exp 0", rnd_valid); else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            ro_in = NUM_RO'($urandom);
            wait_cyc(1);
            if (rnd_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL stop_stays_idle got %b exp 0", seen); else n_pass++;
        stop = 1'b1;
        start = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        start = 1'b0;
        n_chk++; if (busy !== 1'b0) $display("FAIL idle_start_stop_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_rst_hold();
        bit done;
        pulse_start();
        feed(WARMUP + DIV, 200, 32'h0, 1'b1, done);
        n_chk++; if (done !== 1'b1) $display("FAIL rsth_word got %b exp 1", done); else n_pass++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_chk++; if (rnd_valid !== 1'b0) $display("FAIL async_valid got %b exp 0", rnd_valid); else n_pass++;
        n_chk++; if (rnd_data !== 8'h00) $display("FAIL async_data got %h exp 00", rnd_data); else n_pass++;
        n_chk++; if (ro_en !== 3'b000) $display("FAIL async_ro_en got %b exp 000", ro_en); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL async_busy got %b exp 0", busy); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cyc(1);
        n_chk++; if (busy !== 1'b0) $display("FAIL rsth_release_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (ro_en !== 3'b000) $display("FAIL rsth_release_ro_en got %b exp 000", ro_en); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start_word();
        test_hold();
        test_back_to_back();
        test_pairs();
        test_stop();
        test_rst_hold();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
